// File: rtl/lamp_pkg.sv
// Shared opcode, mode and state encodings for the lamp controller,
// plus the default configuration constants.
package lamp_pkg;

    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_START    = 3'd1,
        OP_STOP     = 3'd2,
        OP_SET_MODE = 3'd3,
        OP_SET_DIV  = 3'd4,
        OP_LOAD_PAT = 3'd5,
        OP_STEP     = 3'd6,
        OP_RSVD     = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        MODE_ROTL   = 2'd0,
        MODE_ROTR   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam int unsigned LAMP_LED_W   = 16;
    localparam int unsigned LAMP_DEF_DIV = 5000000;
    localparam int unsigned LAMP_DIV_W   = 32;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/lamp_prescaler.sv
// Step-rate prescaler: counts enabled cycles and emits one step every div cycles.
// A concurrent command (hold) suppresses a due step and parks the count on it.
module lamp_prescaler
    import lamp_pkg::*;
#(
    parameter int unsigned DIV_W   = LAMP_DIV_W,
    parameter int unsigned DEF_DIV = LAMP_DEF_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             hold,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_val,
    output logic             step
);

    logic [DIV_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             terminal;

    assign terminal = (count_q == (div_q - DIV_W'(1)));
    assign step     = en & terminal & ~hold;

    always_comb begin
        count_d = count_q;
        div_d   = div_q;
        if (div_load) begin
            div_d   = (div_val == '0) ? DIV_W'(1) : div_val;
            count_d = '0;
        end else if (clr) begin
            count_d = '0;
        end else if (en) begin
            // A held terminal count stays put so the step fires on the next free cycle.
            if (terminal) begin
                count_d = hold ? count_q : '0;
            end else begin
                count_d = count_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            div_q   <= DIV_W'(DEF_DIV);
        end else begin
            count_q <= count_d;
            div_q   <= div_d;
        end
    end

endmodule

// File: rtl/lamp_ctrl.sv
// LED pattern controller: command decode, run/pause FSM and pattern register,
// with step timing delegated to lamp_prescaler.
module lamp_ctrl
    import lamp_pkg::*;
#(
    parameter int unsigned LED_W   = LAMP_LED_W,
    parameter int unsigned DEF_DIV = LAMP_DEF_DIV,
    parameter int unsigned DIV_W   = LAMP_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [DIV_W-1:0] cmd_arg,
    output logic [LED_W-1:0] led,
    output logic             tick,
    output logic [1:0]       state
);

    state_e           state_q, state_d;
    logic [LED_W-1:0] led_q, led_d;
    logic             tick_q, tick_d;
    mode_e            mode_q, mode_d;
    logic             dir_q, dir_d;

    op_e  op;
    logic accept;
    logic running;
    logic presc_step;
    logic manual_step;
    logic do_step;
    logic cnt_clr;
    logic div_load;

    // Returns {new_dir, new_pattern}; bounce flips and rotates in the same step.
    function automatic logic [LED_W:0] step_pattern(
        input logic [LED_W-1:0] pat,
        input mode_e            mode,
        input logic             dir_right
    );
        logic             d;
        logic [LED_W-1:0] p;
        d = dir_right;
        p = pat;
        unique case (mode)
            MODE_ROTL: p = {pat[LED_W-2:0], pat[LED_W-1]};
            MODE_ROTR: p = {pat[0], pat[LED_W-1:1]};
            MODE_BOUNCE: begin
                if (!dir_right && pat[LED_W-1]) begin
                    d = DIR_RIGHT;
                end else if (dir_right && pat[0]) begin
                    d = DIR_LEFT;
                end
                p = (d == DIR_RIGHT) ? {pat[0], pat[LED_W-2+1:1]}
                                     : {pat[LED_W-2:0], pat[LED_W-1]};
            end
            MODE_BLINK: p = ~pat;
            default: p = pat;
        endcase
        return {d, p};
    endfunction

    assign cmd_ready = rst;
    assign accept    = cmd_valid & cmd_ready;
    assign running   = (state_q == ST_RUN);
    assign op        = op_e'(cmd_op);

    lamp_prescaler #(
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (running),
        .clr      (cnt_clr),
        .hold     (accept),
        .div_load (div_load),
        .div_val  (cmd_arg),
        .step     (presc_step)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        dir_d       = dir_q;
        led_d       = led_q;
        cnt_clr     = 1'b0;
        div_load    = 1'b0;
        manual_step = 1'b0;

        if (accept) begin
            case (op)
                OP_START: begin
                    if (state_q == ST_IDLE) begin
                        state_d = ST_RUN;
                        cnt_clr = 1'b1;
                    end else if (state_q == ST_PAUSE) begin
                        state_d = ST_RUN;
                    end
                end
                OP_STOP: begin
                    if (running) begin
                        state_d = ST_PAUSE;
                    end
                end
                OP_SET_MODE: begin
                    mode_d = mode_e'(cmd_arg[1:0]);
                    dir_d  = DIR_LEFT;
                end
                OP_SET_DIV: div_load = 1'b1;
                OP_LOAD_PAT: begin
                    led_d = (cmd_arg[LED_W-1:0] == '0) ? LED_W'(1) : cmd_arg[LED_W-1:0];
                end
                OP_STEP: manual_step = ~running;
                default: ;
            endcase
        end

        // Prescaler steps only occur in command-free cycles, so they never race a load.
        do_step = presc_step | manual_step;
        if (do_step) begin
            {dir_d, led_d} = step_pattern(led_q, mode_q, dir_q);
        end
        tick_d = do_step;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            led_q   <= LED_W'(1);
            tick_q  <= 1'b0;
            mode_q  <= MODE_ROTL;
            dir_q   <= DIR_LEFT;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            tick_q  <= tick_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
        end
    end

    assign led   = led_q;
    assign tick  = tick_q;
    assign state = state_q;

endmodule

// File: tb/tb_lamp_ctrl.sv
// Testbench for lamp_ctrl: directed scenarios plus random commands, checked
// every cycle against a behavioural model of the lamp controller.
module tb_lamp_ctrl;

    localparam int LW = 16;
    localparam int DW = 32;
    localparam int DD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [2:0]    cmd_op = 3'd0;
    logic [DW-1:0] cmd_arg = '0;
    logic          cmd_ready;
    logic [LW-1:0] led;
    logic          tick;
    logic [1:0]    state;

    int vectors = 0;
    int miscompares = 0;

    lamp_ctrl #(.LED_W(LW), .DEF_DIV(DD), .DIV_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .led       (led),
        .tick      (tick),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model state
    bit            m_known = 1'b0;
    int            m_state;
    int unsigned   m_count;
    int unsigned   m_div;
    logic [LW-1:0] m_led;
    int            m_mode;
    bit            m_right;
    bit            m_tick;

    function automatic logic [LW-1:0] rot(input logic [LW-1:0] p, input bit right);
        if (right) return (p >> 1) | (p << (LW - 1));
        return (p << 1) | (p >> (LW - 1));
    endfunction

    task automatic model_cycle(input logic r, input logic v, input logic [2:0] op,
                               input logic [DW-1:0] a);
        int          st0;
        int unsigned c0;
        int unsigned last;
        bit          stp;
        if (r !== 1'b1) begin
            m_known = 1'b1;
            m_state = 0; m_count = 0; m_div = DD; m_led = 1;
            m_mode = 0; m_right = 1'b0; m_tick = 1'b0;
            return;
        end
        if (!m_known) return;
        st0  = m_state;
        c0   = m_count;
        last = m_div - 1;
        stp  = 1'b0;
        if (v) begin
            if (st0 == 1) m_count = (c0 == last) ? c0 : c0 + 1;
            case (op)
                3'd1: begin
                    if (st0 == 0) m_count = 0;
                    if (st0 != 1) m_state = 1;
                end
                3'd2: if (st0 == 1) m_state = 2;
                3'd3: begin m_mode = int'(a[1:0]); m_right = 1'b0; end
                3'd4: begin m_div = (a == 0) ? 1 : a; m_count = 0; end
                3'd5: m_led = (a[LW-1:0] == 0) ? LW'(1) : a[LW-1:0];
                3'd6: stp = (st0 != 1);
                default: ;
            endcase
        end else if (st0 == 1) begin
            if (c0 == last) begin
                stp = 1'b1;
                m_count = 0;
            end else begin
                m_count = c0 + 1;
            end
        end
        if (stp) begin
            case (m_mode)
                0: m_led = rot(m_led, 1'b0);
                1: m_led = rot(m_led, 1'b1);
                2: begin
                    if (!m_right && m_led[LW-1]) m_right = 1'b1;
                    else if (m_right && m_led[0]) m_right = 1'b0;
                    m_led = rot(m_led, m_right);
                end
                default: m_led = ~m_led;
            endcase
        end
        m_tick = stp;
    endtask

    // Cycle-by-cycle compare against the model
    always @(posedge clk) begin
        logic          r_s, v_s;
        logic [2:0]    op_s;
        logic [DW-1:0] a_s;
        r_s = rst; v_s = cmd_valid; op_s = cmd_op; a_s = cmd_arg;
        model_cycle(r_s, v_s, op_s, a_s);
        #1;
        if (m_known) begin
            check("model_led", led, m_led);
            check("model_tick", tick, m_tick);
            check("model_state", state, m_state);
            check("model_ready", cmd_ready, r_s);
        end
    end

    task automatic cyc(input logic v, input logic [2:0] op, input logic [DW-1:0] a);
        cmd_valid = v; cmd_op = op; cmd_arg = a;
        @(posedge clk);
        #2;
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = '0;
    endtask

    task automatic wait_tick(input int maxc, input string nm, output int n);
        n = 0;
        do begin
            cyc(1'b0, 3'd0, '0);
            n++;
        end while (tick !== 1'b1 && n < maxc);
        if (tick !== 1'b1) check({nm, "_timeout"}, tick, 1);
    endtask

    initial begin
        int n;
        int rnd;
        logic [2:0] rop;

        // Reset state
        rst = 1'b0;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check("rst_led", led, 16'h0001);
        check("rst_state", state, 0);
        check("rst_tick", tick, 0);
        check("rst_ready", cmd_ready, 0);
        rst = 1'b1;
        cyc(0, 0, 0);
        check("ready_high", cmd_ready, 1);

        // Rotate left every 4 cycles
        cyc(1, 3'd1, 0);
        check("start_state", state, 1);
        check("start_led", led, 16'h0001);
        wait_tick(8, "rotl1", n);
        check("rotl1_gap", n, 4);
        check("rotl1_led", led, 16'h0002);
        wait_tick(8, "rotl2", n);
        check("rotl2_gap", n, 4);
        check("rotl2_led", led, 16'h0004);

        // Bounce from the top bit
        cyc(1, 3'd2, 0);
        check("stop_state", state, 2);
        cyc(1, 3'd3, 2);
        cyc(1, 3'd5, 32'h8000);
        check("load_led", led, 16'h8000);
        check("load_tick", tick, 0);
        cyc(1, 3'd1, 0);
        wait_tick(8, "bnc_first", n);
        check("bnc_first_led", led, 16'h4000);
        for (int i = 13; i >= 0; i--) begin
            wait_tick(8, "bnc_down", n);
            check("bnc_down_led", led, 64'(1) << i);
        end
        wait_tick(8, "bnc_rev_lo", n);
        check("bnc_rev_lo_led", led, 16'h0002);
        for (int i = 2; i <= 15; i++) begin
            wait_tick(8, "bnc_up", n);
            check("bnc_up_led", led, 64'(1) << i);
        end
        wait_tick(8, "bnc_rev_hi", n);
        check("bnc_rev_hi_led", led, 16'h4000);

        // Divider of 0 behaves as 1
        cyc(1, 3'd4, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0);
            check("div1_tick", tick, 1);
        end
        cyc(1, 3'd2, 0);
        check("div1_stop_state", state, 2);
        check("div1_stop_tick", tick, 0);
        cyc(0, 0, 0);
        check("pause_tick", tick, 0);

        // Manual step in PAUSE, collision and preserved count
        cyc(1, 3'd6, 0);
        check("manual_tick", tick, 1);
        cyc(0, 0, 0);
        check("manual_tick_off", tick, 0);
        cyc(1, 3'd4, 4);
        cyc(1, 3'd1, 0);
        wait_tick(8, "div4", n);
        check("div4_gap", n, 4);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 3'd0, 0);
        check("collide_tick", tick, 0);
        cyc(0, 0, 0);
        check("collide_late_tick", tick, 1);
        cyc(0, 0, 0);
        cyc(1, 3'd2, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 3'd1, 0);
        wait_tick(8, "resume", n);
        check("resume_gap", n, 2);

        // Zero pattern load, reserved op, START in RUN
        cyc(1, 3'd5, 0);
        check("load0_led", led, 16'h0001);
        check("load0_tick", tick, 0);
        cyc(1, 3'd7, 32'hFFFF_FFFF);
        cyc(1, 3'd1, 0);
        check("start_in_run_state", state, 1);

        // Reset in the middle of RUN
        rst = 1'b0;
        cyc(0, 0, 0);
        check("midrst_led", led, 16'h0001);
        check("midrst_state", state, 0);
        check("midrst_tick", tick, 0);
        check("midrst_ready", cmd_ready, 0);
        rst = 1'b1;
        cyc(1, 3'd1, 0);
        wait_tick(8, "post_rst", n);
        check("post_rst_gap", n, 4);

        // Random commands
        for (int k = 0; k < 4000; k++) begin
            rst = ($urandom_range(0, 299) != 0);
            rnd = $urandom_range(0, 2);
            rop = 3'($urandom_range(0, 7));
            if (rop == 3'd4) cyc(rnd == 0, rop, DW'($urandom_range(0, 5)));
            else cyc(rnd == 0, rop, DW'($urandom));
        end
        rst = 1'b1;
        cyc(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lamp_ctrl.md
LAMP_CTRL -- requirements
Module: lamp_ctrl

Interface
REQ-001 Parameter LED_W, default 16, LED bank width.
REQ-002 Parameter DEF_DIV, default 5000000, reset step period in clk cycles.
REQ-003 Parameter DIV_W, default 32, width of the period register and counter.
REQ-004 clk  in  1  sole clock; all logic on posedge.
REQ-005 rst  in  1  reset, synchronous and active-low; one clock.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command accepted when valid&ready.
REQ-008 cmd_op  in  3  opcode: 0 NOP, 1 START, 2 STOP, 3 SET_MODE, 4 SET_DIV, 5 LOAD_PAT, 6 STEP, 7 reserved.
REQ-009 cmd_arg  in  DIV_W  command operand.
REQ-010 led  out  LED_W  registered LED drive.
REQ-011 tick  out  1  registered one-cycle pulse coincident with each led update from a step.
REQ-012 state  out  2  registered FSM state: 0 IDLE, 1 RUN, 2 PAUSE.

Function
REQ-013 cmd_ready SHALL be 1 whenever rst is high, and 0 while rst is low.
REQ-014 An accepted command SHALL take effect at the accepting edge; its results are visible the next cycle.
REQ-015 FSM: IDLE-START->RUN (count cleared); RUN-STOP->PAUSE; PAUSE-START->RUN (count preserved); STOP in IDLE/PAUSE SHALL be ignored; START in RUN SHALL be ignored.
REQ-016 In RUN, count SHALL increment each cycle; when count==div-1 a step SHALL occur and count SHALL return to 0, giving one step per div cycles.
REQ-017 Step by mode: 0 ROTL rotate left 1; 1 ROTR rotate right 1; 2 BOUNCE rotate in dir, dir flips to right when led[LED_W-1] set while moving left, and to left when led[0] set while moving right, with the flip and rotate in the same step; 3 BLINK led<=~led.
REQ-018 SET_MODE SHALL load cmd_arg[1:0] and set dir=left; it does not alter led or count.
REQ-019 SET_DIV SHALL load cmd_arg and clear count; a value of 0 SHALL be stored as 1.
REQ-020 LOAD_PAT SHALL load cmd_arg[LED_W-1:0] into led without a tick; a value of 0 SHALL load 1.
REQ-021 STEP SHALL perform exactly one step with tick in IDLE or PAUSE, and SHALL be ignored in RUN.
REQ-022 Collision: if a command is accepted in a RUN cycle with count==div-1, the command wins, the step is suppressed, and count holds at div-1 unless the command clears it, so the step fires next cycle.
REQ-023 NOP, op 7, and ignored commands SHALL change no state.
REQ-024 tick SHALL be 0 in every cycle without a step.

Reset
REQ-025 While rst is low at a posedge: led=1, tick=0, state=IDLE, count=0, div=DEF_DIV, mode=ROTL, dir=left.
REQ-026 Reset asserted mid-RUN SHALL abort immediately with no pending step or tick surviving.

Structure
REQ-027 Package lamp_pkg SHALL hold the opcode, mode, and state enumerations and the default constants.
REQ-028 Sub-module lamp_prescaler (counter, div input, enable, clear, hold, step output) SHALL implement REQ-016/019/022; lamp_ctrl holds the FSM, command decode, and pattern register.

Verification (DEF_DIV=4 for simulation)
REQ-029 Release reset, START -> led 0x0001, then 0x0002, 0x0004, ... every 4 cycles with tick pulses 4 cycles apart; state=1.
REQ-030 SET_MODE 2, LOAD_PAT 0x8000, START -> 0x4000 ... 0x0001 then 0x0002 (reversal); also 0x0001 -> 0x0002 ... 0x8000 -> 0x4000.
REQ-031 SET_DIV 0 in RUN -> led steps every cycle; STOP still accepted; state=2 next cycle; no further ticks.
REQ-032 In PAUSE, STEP -> exactly one tick and one rotate; START -> next step after the remaining preserved count; a command at count==3 delays that step by 1 cycle.
REQ-033 LOAD_PAT 0 -> led 0x0001 with no tick; op 7 and START in RUN -> no change.
REQ-034 rst low mid-RUN -> next cycle led 0x0001, state 0, cmd_ready 0, tick 0; after release, div is back to 4.
